// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Countdown-scoreboard pipeline hazard controller producing fetch/
//            decode stall, flush and freeze controls. Optional performance
//            counters are enabled by defining HAZARD_PERF_EN.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LAT  = 4,
    parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                D_valid,
    input  logic [REG_AW-1:0]   D_rs1_addr,
    input  logic                D_rs1_used,
    input  logic [REG_AW-1:0]   D_rs2_addr,
    input  logic                D_rs2_used,
    input  logic [REG_AW-1:0]   D_rd_addr,
    input  logic                D_rd_wen,
    input  logic [LAT_W-1:0]    D_lat,
    input  logic                E_pc_redirect,
    input  logic                mem_stall,
    output logic                F_stall_pc,
    output logic                F_stall_fetch_reg,
    output logic                F_flush_fetch_reg,
    output logic                D_flush_decode_reg,
    output logic                pipe_freeze,
    output logic                D_issue,
    output logic [NUM_REGS-1:0] busy_mask
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_mem_stall_cycles,
    output logic [31:0]         perf_flushes
`endif
);

    localparam logic [LAT_W-1:0] c_MAX_LAT = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] w_cnt [1:NUM_REGS-1];
    logic [LAT_W-1:0] w_cnt_rs1;
    logic [LAT_W-1:0] w_cnt_rs2;
    logic [LAT_W-1:0] w_cnt_rd;
    logic [LAT_W-1:0] w_lat;
    logic             w_raw_hz;
    logic             w_waw_hz;
    logic             w_hz;
    logic             w_alloc;

    // Out-of-range lat is clamped so a bad encoding can never exceed the counter range.
    assign w_lat = (D_lat > c_MAX_LAT) ? c_MAX_LAT : D_lat;

    // Address 0 and addresses beyond NUM_REGS read as an idle counter.
    always_comb begin
        w_cnt_rs1 = '0;
        w_cnt_rs2 = '0;
        w_cnt_rd  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (D_rs1_addr == REG_AW'(r)) w_cnt_rs1 = w_cnt[r];
            if (D_rs2_addr == REG_AW'(r)) w_cnt_rs2 = w_cnt[r];
            if (D_rd_addr  == REG_AW'(r)) w_cnt_rd  = w_cnt[r];
        end
    end

    assign w_raw_hz = D_valid &
                      ((D_rs1_used & (D_rs1_addr != '0) & (w_cnt_rs1 != '0)) |
                       (D_rs2_used & (D_rs2_addr != '0) & (w_cnt_rs2 != '0)));
    assign w_waw_hz = D_valid & D_rd_wen & (D_rd_addr != '0) & (w_cnt_rd > w_lat);
    assign w_hz     = w_raw_hz | w_waw_hz;

    always_comb begin
        F_stall_pc         = 1'b0;
        F_stall_fetch_reg  = 1'b0;
        F_flush_fetch_reg  = 1'b0;
        D_flush_decode_reg = 1'b0;
        pipe_freeze        = 1'b0;
        D_issue            = 1'b0;
        if (mem_stall) begin
            pipe_freeze       = 1'b1;
            F_stall_pc        = 1'b1;
            F_stall_fetch_reg = 1'b1;
        end else if (E_pc_redirect) begin
            F_flush_fetch_reg  = 1'b1;
            D_flush_decode_reg = 1'b1;
        end else if (w_hz) begin
            F_stall_pc         = 1'b1;
            F_stall_fetch_reg  = 1'b1;
            D_flush_decode_reg = 1'b1;
        end else begin
            D_issue = D_valid;
        end
    end

    assign w_alloc = D_issue & D_rd_wen & (D_rd_addr != '0);

    assign busy_mask[0] = 1'b0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
            logic [LAT_W-1:0] r_cnt;
            logic             w_load;

            assign w_load = w_alloc & (D_rd_addr == REG_AW'(r));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (!mem_stall) begin
                    if (w_load) begin
                        r_cnt <= w_lat;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - LAT_W'(1);
                    end
                end
            end

            assign w_cnt[r]     = r_cnt;
            assign busy_mask[r] = (r_cnt != '0);
        end
    endgenerate

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_mem;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_stall <= '0;
            r_perf_mem   <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_hz && !mem_stall)          r_perf_stall <= r_perf_stall + 32'd1;
            if (mem_stall)                   r_perf_mem   <= r_perf_mem + 32'd1;
            if (E_pc_redirect && !mem_stall) r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_stall_cycles     = r_perf_stall;
    assign perf_mem_stall_cycles = r_perf_mem;
    assign perf_flushes          = r_perf_flush;
`endif

`ifndef SYNTHESIS
    a_lat_legal: assert property (@(posedge clk) disable iff (!reset)
        D_valid |-> (D_lat <= c_MAX_LAT));
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Table-driven directed bench for hazard_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int MAX_LAT  = 4;
    localparam int LAT_W    = 3;

    // {F_stall_pc, F_stall_fetch_reg, F_flush_fetch_reg, D_flush_decode_reg, pipe_freeze, D_issue}
    localparam logic [5:0] c_IDLE  = 6'b000000;
    localparam logic [5:0] c_ISSUE = 6'b000001;
    localparam logic [5:0] c_HZ    = 6'b110100;
    localparam logic [5:0] c_REDIR = 6'b001100;
    localparam logic [5:0] c_FRZ   = 6'b110010;

    logic                clk;
    logic                reset;
    logic                D_valid;
    logic [REG_AW-1:0]   D_rs1_addr;
    logic                D_rs1_used;
    logic [REG_AW-1:0]   D_rs2_addr;
    logic                D_rs2_used;
    logic [REG_AW-1:0]   D_rd_addr;
    logic                D_rd_wen;
    logic [LAT_W-1:0]    D_lat;
    logic                E_pc_redirect;
    logic                mem_stall;
    logic                F_stall_pc;
    logic                F_stall_fetch_reg;
    logic                F_flush_fetch_reg;
    logic                D_flush_decode_reg;
    logic                pipe_freeze;
    logic                D_issue;
    logic [NUM_REGS-1:0] busy_mask;
`ifdef HAZARD_PERF_EN
    logic [31:0]         perf_stall_cycles;
    logic [31:0]         perf_mem_stall_cycles;
    logic [31:0]         perf_flushes;
`endif

    hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .MAX_LAT  (MAX_LAT)
    ) u_dut (
        .clk                (clk),
        .reset              (reset),
        .D_valid            (D_valid),
        .D_rs1_addr         (D_rs1_addr),
        .D_rs1_used         (D_rs1_used),
        .D_rs2_addr         (D_rs2_addr),
        .D_rs2_used         (D_rs2_used),
        .D_rd_addr          (D_rd_addr),
        .D_rd_wen           (D_rd_wen),
        .D_lat              (D_lat),
        .E_pc_redirect      (E_pc_redirect),
        .mem_stall          (mem_stall),
        .F_stall_pc         (F_stall_pc),
        .F_stall_fetch_reg  (F_stall_fetch_reg),
        .F_flush_fetch_reg  (F_flush_fetch_reg),
        .D_flush_decode_reg (D_flush_decode_reg),
        .pipe_freeze        (pipe_freeze),
        .D_issue            (D_issue),
        .busy_mask          (busy_mask)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles     (perf_stall_cycles),
        .perf_mem_stall_cycles (perf_mem_stall_cycles),
        .perf_flushes          (perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             valid;
        logic [4:0]       rs1;
        logic             u1;
        logic [4:0]       rs2;
        logic             u2;
        logic [4:0]       rd;
        logic             wen;
        logic [2:0]       lat;
        logic             redir;
        logic             mstall;
        logic [5:0]       ctl;
        logic [31:0]      busy;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(string nm, logic v, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic [4:0] rd, logic wen,
                                logic [2:0] lat, logic redir, logic ms,
                                logic [5:0] ctl, logic [31:0] busy);
        vec_t t;
        t.name = nm; t.valid = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.wen = wen; t.lat = lat; t.redir = redir; t.mstall = ms;
        t.ctl = ctl; t.busy = busy;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        D_valid       = t.valid;
        D_rs1_addr    = t.rs1;
        D_rs1_used    = t.u1;
        D_rs2_addr    = t.rs2;
        D_rs2_used    = t.u2;
        D_rd_addr     = t.rd;
        D_rd_wen      = t.wen;
        D_lat         = t.lat;
        E_pc_redirect = t.redir;
        mem_stall     = t.mstall;
    endtask

    task automatic check(input string nm, input logic [5:0] ctl, input logic [31:0] busy);
        logic [5:0] got;
        got = {F_stall_pc, F_stall_fetch_reg, F_flush_fetch_reg,
               D_flush_decode_reg, pipe_freeze, D_issue};
        n_tests++;
        if (got !== ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", nm, got, ctl);
        end
        n_tests++;
        if (busy_mask !== busy) begin
            n_fail++;
            $display("FAIL %s busy_mask: got %h expected %h", nm, busy_mask, busy);
        end
    endtask

    task automatic step(input vec_t t);
        @(negedge clk);
        drive(t);
        #2;
        check(t.name, t.ctl, t.busy);
    endtask

    vec_t idle;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDLE, 32'h0);

        // load-use on x5
        vecs.push_back(mk("ld_x5",     1, 0, 0, 0, 0, 5, 1, 1, 0, 0, c_ISSUE, 32'h0));
        vecs.push_back(mk("use_x5_st", 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, c_HZ,    32'h20));
        vecs.push_back(mk("use_x5_go", 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, c_ISSUE, 32'h0));
        // ALU result is forwarded: no stall
        vecs.push_back(mk("alu_x3",    1, 0, 0, 0, 0, 3, 1, 0, 0, 0, c_ISSUE, 32'h0));
        vecs.push_back(mk("use_x3",    1, 3, 1, 3, 1, 4, 1, 0, 0, 0, c_ISSUE, 32'h0));
        // WAW on x7: lat 4 then lat 1
        vecs.push_back(mk("x7_lat4",   1, 0, 0, 0, 0, 7, 1, 4, 0, 0, c_ISSUE, 32'h0));
        vecs.push_back(mk("waw_c4",    1, 0, 0, 0, 0, 7, 1, 1, 0, 0, c_HZ,    32'h80));
        vecs.push_back(mk("waw_c3",    1, 0, 0, 0, 0, 7, 1, 1, 0, 0, c_HZ,    32'h80));
        vecs.push_back(mk("waw_c2",    1, 0, 0, 0, 0, 7, 1, 1, 0, 0, c_HZ,    32'h80));
        vecs.push_back(mk("waw_go",    1, 0, 0, 0, 0, 7, 1, 1, 0, 0, c_ISSUE, 32'h80));
        vecs.push_back(mk("x7_cnt1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDLE,  32'h80));
        vecs.push_back(mk("x7_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDLE,  32'h0));
        // x0 is never tracked
        vecs.push_back(mk("wr_x0",     1, 0, 0, 0, 0, 0, 1, 3, 0, 0, c_ISSUE, 32'h0));
        vecs.push_back(mk("rd_x0",     1, 0, 1, 0, 1, 8, 1, 0, 0, 0, c_ISSUE, 32'h0));
        // redirect outranks a RAW hazard and allocates nothing
        vecs.push_back(mk("x9_lat2",   1, 0, 0, 0, 0, 9, 1, 2, 0, 0, c_ISSUE, 32'h0));
        vecs.push_back(mk("redir_raw", 1, 0, 0, 9, 1, 10, 1, 0, 1, 0, c_REDIR, 32'h200));
        vecs.push_back(mk("x10_free",  1, 10, 1, 0, 0, 0, 0, 0, 0, 0, c_ISSUE, 32'h200));
        vecs.push_back(mk("x9_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDLE,  32'h0));
        // mem_stall outranks everything and blocks allocation
        vecs.push_back(mk("ms_noissue",1, 0, 0, 0, 0, 11, 1, 2, 0, 1, c_FRZ,  32'h0));
        vecs.push_back(mk("ms_noalloc",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDLE,  32'h0));
        vecs.push_back(mk("ms_redir",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, c_FRZ,   32'h0));
        vecs.push_back(mk("redir_only",0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_REDIR, 32'h0));

        // reset state
        reset = 1'b0;
        drive(idle);
        @(negedge clk);
        #2;
        check("reset", c_IDLE, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // stall on x5 held across five mem_stall cycles
        step(mk("ms_ld_x5", 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, c_ISSUE, 32'h0));
        for (int i = 0; i < 5; i++)
            step(mk("ms_hold", 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, c_FRZ, 32'h20));
        step(mk("ms_rel_st", 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, c_HZ,    32'h20));
        step(mk("ms_rel_go", 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, c_ISSUE, 32'h0));

        // asynchronous reset mid-count
        step(mk("rst_ld_x12", 1, 0, 0, 0, 0, 12, 1, 4, 0, 0, c_ISSUE, 32'h0));
        step(mk("rst_busy",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDLE, 32'h1000));
        #1 reset = 1'b0;
        #1 check("rst_async", c_IDLE, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(mk("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDLE, 32'h0));
        step(mk("rst_reuse", 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, c_ISSUE, 32'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
